jericalla_multiciclo: RTL and testbench

Parametrised multi-cycle datapath for the Jericalla line. It replaces externally sequenced register-file, ALU and data-memory strobes with an internal FSM driven by a valid/ready instruction stream. Results are returned on a valid/ready completion stream, and the block keeps a retired-instruction counter. It sits between the instruction source and any downstream consumer/demux of results.

---
 rtl/jericalla_multiciclo_pkg.sv | 9 +
 rtl/jericalla_multiciclo_if.sv | 31 +++
 rtl/jericalla_multiciclo_alu.sv | 27 ++
 rtl/jericalla_multiciclo.sv | 93 +++++++++
 tb/tb_jericalla_multiciclo.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/jericalla_multiciclo_pkg.sv
// jericalla_pkg: opcode, ALU operation and FSM state encodings shared by the
// Jericalla multi-cycle datapath.
package jericalla_pkg;
    typedef enum logic [1:0] {OP_ALU, OP_LOADI, OP_LOAD, OP_STORE} opcode_e;
    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL
    } alu_op_e;
    typedef enum logic [1:0] {IDLE, EXEC, MEM, WB} state_e;
endpackage

// File: rtl/jericalla_multiciclo_if.sv
// jericalla_multiciclo_if: instruction and completion streams plus the
// retired-instruction count of the Jericalla datapath.
interface jericalla_multiciclo_if #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int IMM_W  = 12,
    parameter int CNT_W  = 16
);
    localparam int RAW = $clog2(NREG);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        opcode;
    logic [2:0]        alu_sel;
    logic [RAW-1:0]    rs1;
    logic [RAW-1:0]    rs2;
    logic [RAW-1:0]    rd;
    logic [IMM_W-1:0]  imm;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [RAW-1:0]    out_rd;
    logic [CNT_W-1:0]  retired;
    modport master (
        output in_valid, opcode, alu_sel, rs1, rs2, rd, imm, out_ready,
        input  in_ready, out_valid, out_data, out_rd, retired
    );
    modport slave (
        input  in_valid, opcode, alu_sel, rs1, rs2, rd, imm, out_ready,
        output in_ready, out_valid, out_data, out_rd, retired
    );
endinterface

// File: rtl/jericalla_multiciclo_alu.sv
// jericalla_alu_p: combinational ALU; shifts use the low log2(DATA_W) bits of b.
module jericalla_alu_p
    import jericalla_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_e           sel,
    output logic [DATA_W-1:0] result
);
    localparam int SW = $clog2(DATA_W);
    logic [SW-1:0] sh;
    assign sh = b[SW-1:0];
    always_comb begin
        case (sel)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SLT: result = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLL: result = a << sh;
            ALU_SRL: result = a >> sh;
        endcase
    end
endmodule

// File: rtl/jericalla_multiciclo.sv
// jericalla_multiciclo: IDLE/EXEC/MEM/WB datapath with register file, data
// memory and a retired-instruction counter behind valid/ready streams.
module jericalla_multiciclo
    import jericalla_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NREG      = 32,
    parameter int MEM_DEPTH = 32,
    parameter int IMM_W     = 12,
    parameter int CNT_W     = 16
) (
    input logic clk,
    input logic rst_n,
    jericalla_multiciclo_if.slave bus
);
    localparam int RAW = $clog2(NREG);
    localparam int MAW = $clog2(MEM_DEPTH);

    state_e            state;
    opcode_e           op;
    alu_op_e           sel;
    logic [RAW-1:0]    rs1, rs2, rd;
    logic [IMM_W-1:0]  imm;
    logic [MAW-1:0]    addr;
    logic [DATA_W-1:0] sdata;
    logic [DATA_W-1:0] rf  [NREG];
    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic [DATA_W-1:0] a, b, simm, alu_res;

    assign a    = rs1 == '0 ? '0 : rf[rs1];
    assign b    = rs2 == '0 ? '0 : rf[rs2];
    assign simm = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    assign bus.in_ready = state == IDLE;

    jericalla_alu_p #(.DATA_W(DATA_W)) alu (.a(a), .b(b), .sel(sel), .result(alu_res));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            op            <= OP_ALU;
            sel           <= ALU_ADD;
            rs1           <= '0;
            rs2           <= '0;
            rd            <= '0;
            imm           <= '0;
            addr          <= '0;
            sdata         <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_rd    <= '0;
            bus.retired   <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    op    <= opcode_e'(bus.opcode);
                    sel   <= alu_op_e'(bus.alu_sel);
                    rs1   <= bus.rs1;
                    rs2   <= bus.rs2;
                    rd    <= bus.rd;
                    imm   <= bus.imm;
                    state <= EXEC;
                end
                EXEC: if (op == OP_ALU || op == OP_LOADI) begin
                    bus.out_data  <= op == OP_ALU ? alu_res : simm;
                    bus.out_rd    <= rd;
                    bus.out_valid <= 1'b1;
                    state         <= WB;
                end else begin
                    addr  <= MAW'(a + simm);
                    sdata <= b;
                    state <= MEM;
                end
                MEM: begin
                    bus.out_data  <= op == OP_LOAD ? mem[addr] : sdata;
                    bus.out_rd    <= op == OP_LOAD ? rd : '0;
                    bus.out_valid <= 1'b1;
                    state         <= WB;
                end
                WB: if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                    bus.retired   <= bus.retired + CNT_W'(1);
                    state         <= IDLE;
                end
            endcase
        end
    end

    // Arrays carry no reset; writes are gated by rst_n so an abort never commits.
    always_ff @(posedge clk) begin
        if (rst_n && state == MEM && op == OP_STORE) mem[addr] <= sdata;
        if (rst_n && state == WB && bus.out_ready && bus.out_rd != '0) rf[bus.out_rd] <= bus.out_data;
    end
endmodule

// File: tb/tb_jericalla_multiciclo.sv
// tb_jericalla_multiciclo: a 32-bit and a 16-bit (NREG=8, CNT_W=4) instance run
// in lockstep against an architectural model of registers, memory and counts.
module tb_jericalla_multiciclo;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    jericalla_multiciclo_if b32 ();
    jericalla_multiciclo_if #(.DATA_W(16), .NREG(8), .CNT_W(4)) b16 ();

    assign b16.in_valid  = b32.in_valid;
    assign b16.opcode    = b32.opcode;
    assign b16.alu_sel   = b32.alu_sel;
    assign b16.rs1       = b32.rs1[2:0];
    assign b16.rs2       = b32.rs2[2:0];
    assign b16.rd        = b32.rd[2:0];
    assign b16.imm       = b32.imm;
    assign b16.out_ready = b32.out_ready;

    jericalla_multiciclo d32 (.clk(clk), .rst_n(rst_n), .bus(b32));
    jericalla_multiciclo #(.DATA_W(16), .NREG(8), .CNT_W(4)) d16 (.clk(clk), .rst_n(rst_n), .bus(b16));

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] mr [2][32];
    logic [31:0] mm [2][32];
    int ret [2];
    logic [31:0] ed [2];
    logic [4:0]  er [2];
    logic busy = 1'b0;
    logic ov_exp = 1'b0;
    logic chk = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Architectural effect of one instruction on lane l (0: 32-bit, 1: 16-bit).
    task automatic model(input int l, input logic [1:0] op, input logic [2:0] sel,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                         input logic [11:0] imm, input bit commit);
        logic [31:0] m  = l != 0 ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        int          w  = l != 0 ? 16 : 32;
        int          k  = l != 0 ? 7 : 31;
        int          i1 = int'(s1) & k;
        int          i2 = int'(s2) & k;
        logic [31:0] a  = i1 == 0 ? 32'd0 : mr[l][i1];
        logic [31:0] b  = i2 == 0 ? 32'd0 : mr[l][i2];
        logic [31:0] si = {{20{imm[11]}}, imm} & m;
        int          ad = int'((a + si) % 32);
        int          dst = op == 2'b11 ? 0 : int'(d) & k;
        logic [31:0] r  = 32'd0;
        case (op)
            2'b00: case (sel)
                3'd0: r = a + b;
                3'd1: r = a - b;
                3'd2: r = a & b;
                3'd3: r = a | b;
                3'd4: r = a ^ b;
                3'd5: r = (l != 0 ? $signed(a[15:0]) < $signed(b[15:0]) : $signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                3'd6: r = a << (b % w);
                default: r = a >> (b % w);
            endcase
            2'b01: r = si;
            2'b10: r = mm[l][ad];
            default: begin
                r = b;
                if (commit) mm[l][ad] = b;
            end
        endcase
        r = r & m;
        ed[l] = r;
        er[l] = 5'(dst);
        if (commit && dst != 0) mr[l][dst] = r;
    endtask

    task automatic issue(input logic [1:0] op, input logic [2:0] sel, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [4:0] d, input logic [11:0] imm,
                         input int hold, input bit lit_on, input logic [31:0] l32,
                         input logic [31:0] l16, input string name);
        bit r;
        @(negedge clk);
        b32.out_ready = 1'b0;
        b32.opcode = op; b32.alu_sel = sel; b32.rs1 = s1; b32.rs2 = s2; b32.rd = d; b32.imm = imm;
        b32.in_valid = 1'b1;
        model(0, op, sel, s1, s2, d, imm, 1'b1);
        model(1, op, sel, s1, s2, d, imm, 1'b1);
        @(posedge clk);
        busy = 1'b1;
        @(negedge clk);
        b32.in_valid = 1'b0;
        b32.opcode = 2'($urandom); b32.rs1 = 5'($urandom); b32.imm = 12'($urandom);
        repeat (op[1] ? 2 : 1) @(posedge clk);
        ov_exp = 1'b1;
        @(negedge clk);
        if (lit_on) begin
            check({name, "_32"}, b32.out_data, l32);
            check({name, "_16"}, 32'(b16.out_data), l16);
        end
        for (int c = 0; c < 64; c++) begin
            r = c >= hold && ($urandom_range(0, 2) != 0 || c >= hold + 20);
            b32.out_ready = r;
            @(posedge clk);
            if (r) begin
                ret[0]++; ret[1]++;
                busy = 1'b0;
                ov_exp = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic reset_checks(input string name);
        check({name, "_valid32"}, 32'(b32.out_valid), 0);
        check({name, "_valid16"}, 32'(b16.out_valid), 0);
        check({name, "_data32"}, b32.out_data, 0);
        check({name, "_data16"}, 32'(b16.out_data), 0);
        check({name, "_rd32"}, 32'(b32.out_rd), 0);
        check({name, "_ret32"}, 32'(b32.retired), 0);
        check({name, "_ret16"}, 32'(b16.retired), 0);
        check({name, "_ready32"}, 32'(b32.in_ready), 1);
        check({name, "_ready16"}, 32'(b16.in_ready), 1);
    endtask

    always @(negedge clk) if (chk) begin
        check("in_ready32", 32'(b32.in_ready), 32'(!busy));
        check("in_ready16", 32'(b16.in_ready), 32'(!busy));
        check("out_valid32", 32'(b32.out_valid), 32'(ov_exp));
        check("out_valid16", 32'(b16.out_valid), 32'(ov_exp));
        if (ov_exp) begin
            check("out_data32", b32.out_data, ed[0]);
            check("out_data16", 32'(b16.out_data), ed[1]);
            check("out_rd32", 32'(b32.out_rd), 32'(er[0]));
            check("out_rd16", 32'(b16.out_rd), 32'(er[1]));
        end
        check("retired32", 32'(b32.retired), ret[0] & 32'hFFFF);
        check("retired16", 32'(b16.retired), ret[1] & 32'hF);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        ret[0] = 0; ret[1] = 0;
        b32.in_valid = 1'b0; b32.out_ready = 1'b0; b32.opcode = '0; b32.alu_sel = '0;
        b32.rs1 = '0; b32.rs2 = '0; b32.rd = '0; b32.imm = '0;
        repeat (2) @(negedge clk);
        reset_checks("reset");
        rst_n = 1'b1;
        chk = 1'b1;
        issue(2'b01, 3'd0, 5'd0, 5'd0, 5'd1, 12'd5,    0, 1, 32'h5, 32'h5, "loadi_r1");
        issue(2'b01, 3'd0, 5'd0, 5'd0, 5'd2, 12'hFFD,  0, 1, 32'hFFFF_FFFD, 32'hFFFD, "loadi_r2");
        @(negedge clk);
        check("retired_two32", 32'(b32.retired), 2);
        check("retired_two16", 32'(b16.retired), 2);
        issue(2'b00, 3'd0, 5'd1, 5'd2, 5'd3, 12'd0,    0, 1, 32'h2, 32'h2, "add");
        issue(2'b00, 3'd1, 5'd2, 5'd1, 5'd4, 12'd0,    0, 1, 32'hFFFF_FFF8, 32'hFFF8, "sub");
        issue(2'b00, 3'd5, 5'd2, 5'd1, 5'd5, 12'd0,    0, 1, 32'h1, 32'h1, "slt");
        issue(2'b01, 3'd0, 5'd0, 5'd0, 5'd6, 12'd33,   0, 1, 32'd33, 32'd33, "loadi_r6");
        issue(2'b00, 3'd6, 5'd1, 5'd6, 5'd7, 12'd0,    0, 1, 32'hA, 32'hA, "sll");
        // Abort an ALU op in EXEC; r3 must keep its value.
        @(negedge clk);
        b32.opcode = 2'b00; b32.alu_sel = 3'd0; b32.rs1 = 5'd1; b32.rs2 = 5'd1; b32.rd = 5'd3;
        b32.in_valid = 1'b1;
        @(posedge clk);
        busy = 1'b1;
        @(negedge clk);
        chk = 1'b0;
        b32.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        reset_checks("abort");
        ret[0] = 0; ret[1] = 0; busy = 1'b0; ov_exp = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk = 1'b1;
        issue(2'b00, 3'd0, 5'd3, 5'd0, 5'd7, 12'd0,    0, 1, 32'h2, 32'h2, "r3_kept");
        issue(2'b11, 3'd0, 5'd1, 5'd2, 5'd9, 12'd2,    0, 1, 32'hFFFF_FFFD, 32'hFFFD, "store7");
        issue(2'b10, 3'd0, 5'd0, 5'd0, 5'd7, 12'd7,    0, 1, 32'hFFFF_FFFD, 32'hFFFD, "load7");
        issue(2'b11, 3'd0, 5'd1, 5'd4, 5'd0, 12'd29,   0, 1, 32'hFFFF_FFF8, 32'hFFF8, "store_wrap");
        issue(2'b10, 3'd0, 5'd0, 5'd0, 5'd6, 12'd2,    0, 1, 32'hFFFF_FFF8, 32'hFFF8, "load_wrap");
        issue(2'b01, 3'd0, 5'd0, 5'd0, 5'd3, 12'd9,    4, 1, 32'd9, 32'd9, "bp_loadi");
        issue(2'b01, 3'd0, 5'd0, 5'd0, 5'd0, 12'd7,    4, 1, 32'd7, 32'd7, "loadi_r0");
        issue(2'b00, 3'd0, 5'd0, 5'd0, 5'd5, 12'd0,    0, 1, 32'd0, 32'd0, "r0_zero");
        issue(2'b01, 3'd0, 5'd0, 5'd0, 5'd1, 12'hFFF,  0, 1, 32'hFFFF_FFFF, 32'hFFFF, "loadi_m1");
        issue(2'b01, 3'd0, 5'd0, 5'd0, 5'd2, 12'd1,    0, 1, 32'h1, 32'h1, "loadi_1");
        issue(2'b00, 3'd7, 5'd1, 5'd2, 5'd3, 12'd0,    0, 1, 32'h7FFF_FFFF, 32'h7FFF, "srl");
        issue(2'b00, 3'd0, 5'd3, 5'd2, 5'd4, 12'd0,    0, 1, 32'h8000_0000, 32'h8000, "add_ovf");
        issue(2'b00, 3'd1, 5'd0, 5'd2, 5'd5, 12'd0,    0, 1, 32'hFFFF_FFFF, 32'hFFFF, "sub_uf");
        for (int i = 1; i < 32; i++)
            issue(2'b01, 3'd0, 5'd0, 5'd0, 5'(i), 12'($urandom), 0, 0, 0, 0, "init_reg");
        for (int i = 0; i < 32; i++)
            issue(2'b11, 3'd0, 5'd0, 5'($urandom_range(1, 31)), 5'd0, 12'(i), 0, 0, 0, 0, "init_mem");
        for (int i = 0; i < 250; i++)
            issue(2'($urandom), 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                  12'($urandom), $urandom_range(0, 2), 0, 0, 0, "rand");
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
